// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with per-register valid flags,
// a one-register-per-cycle clear sweep, and write-first bypass (REGFILE_BYPASS_EN).
module regfile_param #(
  parameter int N = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLKb,
  input  logic             RST,
  input  logic [N-1:0]     D,
  input  logic             ENW,
  input  logic [AW-1:0]    WRA,
  input  logic             ENR0,
  input  logic [AW-1:0]    RDA0,
  input  logic             ENR1,
  input  logic [AW-1:0]    RDA1,
  input  logic             CLR,
  output logic [N-1:0]     Q0,
  output logic [N-1:0]     Q1,
  output logic [DEPTH-1:0] VLD,
  output logic             BUSY
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "regfile_param: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic            wr_ok;

  // A write lands only when idle and not displaced by a clear request.
  assign wr_ok = (state_q == IDLE) && ENW && !CLR;

  assign BUSY = (state_q == SWEEP);
  assign VLD  = vld_q;

  // Sweep sequencer: next state and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and sweep pointer registers.
  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage and valid flags: sweep clears one entry per edge, else write.
  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[ptr_q] <= '0;
      vld_q[ptr_q] <= 1'b0;
    end else if (wr_ok) begin
      mem_q[WRA] <= D;
      vld_q[WRA] <= 1'b1;
    end
  end

  // Read muxes: zero when disabled, optional forwarding of the accepted write.
  always_comb begin
    Q0 = '0;
    Q1 = '0;
    if (ENR0) begin
      Q0 = mem_q[RDA0];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && RDA0 == WRA) begin
        Q0 = D;
      end
`else
`endif
    end
    if (ENR1) begin
      Q1 = mem_q[RDA1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && RDA1 == WRA) begin
        Q1 = D;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and randomized checks of regfile_param
// against a behavioural array model.
module tb_regfile_param;
  localparam int N = 10;
  localparam int DEPTH = 4;
  localparam int AW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLKb = 1'b0;
  logic RST;
  logic [N-1:0] D;
  logic ENW, ENR0, ENR1, CLR;
  logic [AW-1:0] WRA, RDA0, RDA1;
  logic [N-1:0] Q0, Q1;
  logic [DEPTH-1:0] VLD;
  logic BUSY;

  always #5 CLKb = ~CLKb;

  regfile_param #(.N(N), .DEPTH(DEPTH)) dut (
    .CLKb(CLKb), .RST(RST), .D(D), .ENW(ENW), .WRA(WRA),
    .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .CLR(CLR), .Q0(Q0), .Q1(Q1), .VLD(VLD), .BUSY(BUSY)
  );

  int ncmp = 0;
  int nerr = 0;

  // reference model
  logic [N-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_vld;
  bit m_busy;
  int m_idx;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_vld = '0;
    m_busy = 1'b0;
    m_idx = 0;
  endtask

  function automatic logic [N-1:0] m_q(logic en, int a);
    if (!en) return '0;
    if (BYP && ENW && !m_busy && !CLR && a == int'(WRA)) return D;
    return m_mem[a];
  endfunction

  task automatic m_edge();
    if (m_busy) begin
      m_mem[m_idx] = '0;
      m_vld[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == DEPTH) m_busy = 1'b0;
    end else if (CLR) begin
      m_busy = 1'b1;
      m_idx = 0;
    end else if (ENW) begin
      m_mem[WRA] = D;
      m_vld[WRA] = 1'b1;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".Q0"}, 32'(Q0), 32'(m_q(ENR0, int'(RDA0))));
    chk({tag, ".Q1"}, 32'(Q1), 32'(m_q(ENR1, int'(RDA1))));
    chk({tag, ".VLD"}, 32'(VLD), 32'(m_vld));
    chk({tag, ".BUSY"}, 32'(BUSY), 32'(m_busy));
  endtask

  task automatic cyc();
    m_edge();
    @(posedge CLKb);
    #1;
  endtask

  task automatic idle_in();
    ENW = 0; CLR = 0; ENR0 = 0; ENR1 = 0;
    D = '0; WRA = '0; RDA0 = '0; RDA1 = '0;
  endtask

  task automatic wr(int a, logic [N-1:0] d);
    ENW = 1; WRA = AW'(a); D = d;
    cyc();
    ENW = 0;
  endtask

  logic [DEPTH-1:0] vld_seq [DEPTH];
  int busy_cnt;

  initial begin
    vld_seq[0] = 4'b1111;
    vld_seq[1] = 4'b1110;
    vld_seq[2] = 4'b1100;
    vld_seq[3] = 4'b1000;
    idle_in();
    RST = 1;
    m_reset();
    ENR0 = 1; ENR1 = 1; RDA0 = 0; RDA1 = 3;
    #2;
    chk("rst.Q0", 32'(Q0), 0);
    chk("rst.Q1", 32'(Q1), 0);
    chk("rst.VLD", 32'(VLD), 0);
    chk("rst.BUSY", 32'(BUSY), 0);
    @(posedge CLKb); #1;
    RST = 0;

    // fill with 0x3FF, then async reset mid-cycle
    for (int i = 0; i < DEPTH; i++) wr(i, 10'h3FF);
    chk("fill.VLD", 32'(VLD), 32'hF);
    RDA0 = 1; RDA1 = 2;
    #1;
    chk("fill.Q0", 32'(Q0), 32'h3FF);
    #2;
    RST = 1;
    #1;
    m_reset();
    chk("amid.Q0", 32'(Q0), 0);
    chk("amid.Q1", 32'(Q1), 0);
    chk("amid.VLD", 32'(VLD), 0);
    chk("amid.BUSY", 32'(BUSY), 0);
    @(posedge CLKb); #1;
    RST = 0;

    // write/read
    wr(2, 10'h155);
    wr(3, 10'h2AA);
    ENR0 = 1; RDA0 = 2; ENR1 = 1; RDA1 = 3;
    #1;
    chk("wr.Q0", 32'(Q0), 32'h155);
    chk("wr.Q1", 32'(Q1), 32'h2AA);
    chk("wr.VLD", 32'(VLD), 32'b1100);
    ENR0 = 0;
    #1;
    chk("wr.Q0dis", 32'(Q0), 0);
    chk("wr.Q1en", 32'(Q1), 32'h2AA);

    // bypass
    wr(1, 10'h001);
    ENW = 1; WRA = 1; D = 10'h0F0; ENR0 = 1; RDA0 = 1;
    #1;
    chk("byp.same", 32'(Q0), BYP ? 32'h0F0 : 32'h001);
    cyc();
    ENW = 0;
    chk("byp.next", 32'(Q0), 32'h0F0);
    chk("byp.VLD", 32'(VLD), 32'b1110);
    wr(1, 10'h0F1);
    chk("ovw.VLD", 32'(VLD), 32'b1110);
    chk("ovw.Q0", 32'(Q0), 32'h0F1);

    // sweep with collisions
    for (int i = 0; i < DEPTH; i++) wr(i, 10'h3FF);
    CLR = 1; ENW = 1; WRA = 0; D = 10'h123;
    ENR0 = 1; RDA0 = 0;
    #1;
    chk("clrw.Q0", 32'(Q0), 32'h3FF);
    cyc();
    CLR = 0; ENW = 0;
    for (int i = 0; i < DEPTH; i++) begin
      RDA0 = AW'(i);
      ENR1 = 1; RDA1 = AW'((i + DEPTH - 1) % DEPTH);
      if (i == 1) begin
        ENW = 1; WRA = 0; D = 10'h055; RDA1 = 0;
      end
      if (i == 2) CLR = 1;
      #1;
      chk($sformatf("sw%0d.BUSY", i), 32'(BUSY), 1);
      chk($sformatf("sw%0d.VLD", i), 32'(VLD), 32'(vld_seq[i]));
      chk($sformatf("sw%0d.Q0", i), 32'(Q0), 32'h3FF);
      if (i > 0) chk($sformatf("sw%0d.Q1", i), 32'(Q1), 0);
      cyc();
      ENW = 0; CLR = 0;
    end
    chk("swend.BUSY", 32'(BUSY), 0);
    chk("swend.VLD", 32'(VLD), 0);
    RDA0 = 0; RDA1 = 3;
    #1;
    chk("swend.Q0", 32'(Q0), 0);
    chk("swend.Q1", 32'(Q1), 0);
    cyc();
    chk("swidle.BUSY", 32'(BUSY), 0);

    // reset mid-sweep
    for (int i = 0; i < DEPTH; i++) wr(i, N'(10'h200 + i));
    CLR = 1;
    cyc();
    CLR = 0;
    cyc();
    cyc();
    chk("rms.VLD", 32'(VLD), 32'b1100);
    #2;
    RST = 1;
    #1;
    m_reset();
    chk("rms.BUSY", 32'(BUSY), 0);
    chk("rms.VLD", 32'(VLD), 0);
    RDA0 = 3; RDA1 = 2;
    #1;
    chk("rms.Q0", 32'(Q0), 0);
    chk("rms.Q1", 32'(Q1), 0);
    @(posedge CLKb); #1;
    RST = 0;
    for (int i = 0; i < DEPTH; i++) wr(i, N'(10'h300 + i));
    CLR = 1;
    cyc();
    CLR = 0;
    cyc();
    chk("rs2.first", 32'(VLD), 32'b1110);
    busy_cnt = 1;
    for (int t = 0; t < 10 && BUSY; t++) begin
      busy_cnt++;
      cyc();
    end
    chk("rs2.len", 32'(busy_cnt), DEPTH);
    chk("rs2.VLD", 32'(VLD), 0);

    // randomized against the model
    for (int t = 0; t < 400; t++) begin
      D = N'($urandom);
      ENW = ($urandom_range(0, 2) != 0);
      WRA = AW'($urandom_range(0, DEPTH - 1));
      ENR0 = ($urandom_range(0, 3) != 0);
      RDA0 = ($urandom_range(0, 3) == 0) ? WRA : AW'($urandom_range(0, DEPTH - 1));
      ENR1 = ($urandom_range(0, 3) != 0);
      RDA1 = ($urandom_range(0, 3) == 0) ? WRA : AW'($urandom_range(0, DEPTH - 1));
      CLR = ($urandom_range(0, 9) == 0);
      #1;
      if ($urandom_range(0, 63) == 0) begin
        RST = 1;
        #1;
        m_reset();
        check_model($sformatf("rnd%0d.rst", t));
        @(posedge CLKb); #1;
        RST = 0;
      end else begin
        check_model($sformatf("rnd%0d", t));
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
